// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states, baud table, frame-length and parity helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2
    } rx_state_e;

    localparam logic [3:0] DBITS_7 = 4'd7;
    localparam logic [3:0] DBITS_8 = 4'd8;
    // Longest frame is 11 samples; the 10-bit shift register is aligned against this.
    localparam logic [3:0] FRAME_MAX = 4'd11;

    // Bit time in 100 MHz clocks for each baud select value.
    function automatic logic [18:0] baud_k(input logic [3:0] sel);
        logic [18:0] k;
        case (sel)
            4'd0:    k = 19'd333333;
            4'd1:    k = 19'd83333;
            4'd2:    k = 19'd41667;
            4'd3:    k = 19'd20833;
            4'd4:    k = 19'd10417;
            4'd5:    k = 19'd5208;
            4'd6:    k = 19'd2604;
            4'd7:    k = 19'd1736;
            4'd8:    k = 19'd868;
            4'd9:    k = 19'd434;
            4'd10:   k = 19'd217;
            default: k = 19'd109;
        endcase
        return k;
    endfunction

    // Samples per frame: start + data + optional parity + stop.
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd2 + (eight ? DBITS_8 : DBITS_7) + {3'b000, pen};
    endfunction

    function automatic logic even_par(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Loadable down-counter; expire_o is high while the count is 1, so a load of L expires L cycles later.
module uart_bit_timer #(
    parameter int W = 19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    output logic [W-1:0] cnt_o,
    output logic         expire_o
);

    logic [W-1:0] cnt_q;

    // Count down to zero and hold there until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1'b1);
        end
    end

    assign cnt_o    = cnt_q;
    assign expire_o = (cnt_q == W'(1'b1));

endmodule

// File: rtl/uart_rx_engine.sv
// UART receive engine: start detect, mid-bit sampling, 7/8 data bits, optional parity, PERR/FERR/OVF.
// Define RX_MAJORITY_EN to take each sample as the 2-of-3 vote of the last three cycles before expiry.
module uart_rx_engine
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int BT_W        = 19
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX,
    input  logic [3:0] BAUD,
    input  logic       EIGHT,
    input  logic       PEN,
    input  logic       OHEL,
    input  logic       READ,
    output logic [7:0] rx_data,
    output logic       RXRDY,
    output logic       PERR,
    output logic       FERR,
    output logic       OVF
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs_s;
    rx_state_e              state_q;
    logic [BT_W-1:0]        k_q;
    logic                   eight_q, pen_q, ohel_q, armed_q;
    logic [3:0]             bit_cnt_q, bit_cnt_d;
    logic [9:0]             sr_q, sr_d;
    logic [7:0]             rx_data_q;
    logic                   rxrdy_q, perr_q, ferr_q, ovf_q;

    logic [BT_W-1:0]        k_live_s, half_s, tmr_val_s, tmr_cnt_s;
    logic                   tmr_load_s, tmr_exp_s, sample_s;
    logic [3:0]             n_s, dbits_s;
    logic [9:0]             w_s;
    logic [7:0]             data_s;
    logic                   par_bit_s, stop_bit_s, par_err_s, done_s;

    // Metastability synchroniser; idles high like the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], RX};
        end
    end
    assign rxs_s = sync_q[SYNC_STAGES-1];

    uart_bit_timer #(.W(BT_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (tmr_load_s),
        .load_val_i (tmr_val_s),
        .cnt_o      (tmr_cnt_s),
        .expire_o   (tmr_exp_s)
    );

`ifdef RX_MAJORITY_EN
    logic maj3_q, maj2_q;

    // Capture the line at counts 3 and 2 so the expiry sample can be voted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            maj3_q <= 1'b1;
            maj2_q <= 1'b1;
        end else begin
            if (tmr_cnt_s == BT_W'(2'd3)) maj3_q <= rxs_s;
            if (tmr_cnt_s == BT_W'(2'd2)) maj2_q <= rxs_s;
        end
    end
    assign sample_s = (maj3_q & maj2_q) | (maj3_q & rxs_s) | (maj2_q & rxs_s);
`else
    logic unused_cnt_s;
    assign unused_cnt_s = ^tmr_cnt_s;
    assign sample_s     = rxs_s;
`endif

    // Frame decode from the shift register as it will look after this sample.
    always_comb begin
        k_live_s   = BT_W'(baud_k(BAUD));
        half_s     = k_live_s >> 1'd1;
        dbits_s    = eight_q ? DBITS_8 : DBITS_7;
        n_s        = frame_len(eight_q, pen_q);
        sr_d       = {sample_s, sr_q[9:1]};
        bit_cnt_d  = bit_cnt_q + 4'd1;
        w_s        = sr_d >> (FRAME_MAX - n_s);
        data_s     = eight_q ? w_s[7:0] : {1'b0, w_s[6:0]};
        par_bit_s  = w_s[dbits_s];
        stop_bit_s = w_s[n_s - 4'd2];
        par_err_s  = pen_q & (par_bit_s != (ohel_q ? ~even_par(data_s) : even_par(data_s)));
        done_s     = (state_q == ST_DATA) && tmr_exp_s && (bit_cnt_d == n_s);
    end

    // Timer load requests: half bit to mid-start, then whole bits.
    always_comb begin
        tmr_load_s = 1'b0;
        tmr_val_s  = k_q;
        case (state_q)
            ST_IDLE: begin
                if (armed_q && !rxs_s) begin
                    tmr_load_s = 1'b1;
                    tmr_val_s  = half_s;
                end else begin
                    tmr_load_s = 1'b0;
                end
            end
            ST_START: begin
                if (tmr_exp_s && !sample_s) tmr_load_s = 1'b1;
                else                        tmr_load_s = 1'b0;
            end
            ST_DATA: begin
                if (tmr_exp_s) tmr_load_s = 1'b1;
                else           tmr_load_s = 1'b0;
            end
            default: tmr_load_s = 1'b0;
        endcase
    end

    // Receive FSM with registered status; completion takes priority over READ.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            k_q       <= '0;
            eight_q   <= 1'b0;
            pen_q     <= 1'b0;
            ohel_q    <= 1'b0;
            armed_q   <= 1'b1;
            bit_cnt_q <= 4'd0;
            sr_q      <= '1;
            rx_data_q <= 8'h00;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (READ) begin
                rxrdy_q <= 1'b0;
                perr_q  <= 1'b0;
                ferr_q  <= 1'b0;
                ovf_q   <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    // After a framing error the line must go high before a new start is accepted.
                    if (!armed_q) begin
                        armed_q <= rxs_s;
                    end else if (!rxs_s) begin
                        state_q   <= ST_START;
                        bit_cnt_q <= 4'd0;
                        k_q       <= k_live_s;
                        eight_q   <= EIGHT;
                        pen_q     <= PEN;
                        ohel_q    <= OHEL;
                    end
                end
                ST_START: begin
                    if (tmr_exp_s) begin
                        if (!sample_s) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= 4'd1;
                        end else begin
                            state_q <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (tmr_exp_s) begin
                        sr_q      <= sr_d;
                        bit_cnt_q <= bit_cnt_d;
                        if (done_s) begin
                            rx_data_q <= data_s;
                            perr_q    <= par_err_s;
                            ferr_q    <= ~stop_bit_s;
                            ovf_q     <= rxrdy_q & ~READ;
                            rxrdy_q   <= 1'b1;
                            armed_q   <= stop_bit_s;
                            state_q   <= ST_IDLE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign RXRDY   = rxrdy_q;
    assign PERR    = perr_q;
    assign FERR    = ferr_q;
    assign OVF     = ovf_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: directed frames push {data,PERR,FERR,OVF}; a monitor checks each delivery.
module tb_uart_rx_engine;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX;
    logic [3:0] BAUD;
    logic       EIGHT, PEN, OHEL, READ;
    logic [7:0] rx_data;
    logic       RXRDY, PERR, FERR, OVF;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    localparam int K8  = 868;
    localparam int K11 = 109;

    always #5 clk = ~clk;

    uart_rx_engine #(.SYNC_STAGES(2), .BT_W(19)) dut (
        .clk     (clk),
        .rst     (rst),
        .RX      (RX),
        .BAUD    (BAUD),
        .EIGHT   (EIGHT),
        .PEN     (PEN),
        .OHEL    (OHEL),
        .READ    (READ),
        .rx_data (rx_data),
        .RXRDY   (RXRDY),
        .PERR    (PERR),
        .FERR    (FERR),
        .OVF     (OVF)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // A delivery is RXRDY rising, or new data while RXRDY stays high.
    initial begin : monitor
        logic       prev_rdy;
        logic [7:0] prev_data;
        logic [10:0] e;
        prev_rdy  = 1'b0;
        prev_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && RXRDY && (!prev_rdy || rx_data != prev_data)) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got data=%h perr=%b ferr=%b ovf=%b, none expected",
                             rx_data, PERR, FERR, OVF);
                end else begin
                    e = exp_q.pop_front();
                    if ({rx_data, PERR, FERR, OVF} !== e) begin
                        errors++;
                        $display("FAIL frame: got data=%h perr=%b ferr=%b ovf=%b expected data=%h perr=%b ferr=%b ovf=%b",
                                 rx_data, PERR, FERR, OVF, e[10:3], e[2], e[1], e[0]);
                    end
                end
            end
            prev_rdy  = RXRDY;
            prev_data = rx_data;
        end
    end

    task automatic idle(input int c);
        RX = 1'b1;
        repeat (c) @(negedge clk);
    endtask

    task automatic pulse_read();
        @(negedge clk);
        READ = 1'b1;
        @(negedge clk);
        READ = 1'b0;
    endtask

    // Drive one frame LSB first; gbit glitches that bit index at its sample point,
    // rd_done pulses READ into the completion edge (2 sync + half + (n-1) bit times).
    task automatic send_frame(input logic [7:0] d, input int nd, input bit pen, input logic pbit,
                              input logic stop, input int k, input int gbit, input bit rd_done);
        logic [11:0] bits;
        int nb, cyc, m, half;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < nd; i++) bits[i+1] = d[i];
        nb = nd + 1;
        if (pen) begin
            bits[nb] = pbit;
            nb++;
        end
        bits[nb] = stop;
        nb++;
        half = k / 2;
        m    = 2 + half + k * (nb - 1);
        cyc  = 0;
        @(negedge clk);
        for (int b = 0; b < nb; b++) begin
            RX = bits[b];
            for (int c = 0; c < k; c++) begin
                @(negedge clk);
                cyc++;
                if (b == gbit && c == half - 1) RX = ~bits[b];
                if (b == gbit && c == half)     RX = bits[b];
                if (rd_done) READ = (cyc == m);
            end
        end
        READ = 1'b0;
    endtask

    initial begin : stim
        int gb;
        rst = 1'b1; RX = 1'b1; READ = 1'b0;
        BAUD = 4'd8; EIGHT = 1'b1; PEN = 1'b0; OHEL = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {rx_data, RXRDY, PERR, FERR, OVF}, {8'h00, 4'b0000});
        rst = 1'b0;
        idle(10);

        // 8N1 at 868 clocks per bit
        exp_q.push_back({8'h55, 3'b000});
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, K8, -1, 1'b0);
        idle(20);
        pulse_read();
        chk("read_clears_flags", {RXRDY, PERR, FERR, OVF}, 4'b0000);
        chk("read_keeps_data", rx_data, 8'h55);

        // 300-cycle low pulse is shorter than half a bit: false start
        RX = 1'b0;
        repeat (300) @(negedge clk);
        idle(1500);
        chk("false_start_no_rdy", RXRDY, 1'b0);

        BAUD = 4'd11;
        // 7E1: 0x41 has even parity 0
        EIGHT = 1'b0; PEN = 1'b1; OHEL = 1'b0;
        exp_q.push_back({8'h41, 3'b100});
        send_frame(8'h41, 7, 1'b1, 1'b1, 1'b1, K11, -1, 1'b0);
        idle(20); pulse_read();
        exp_q.push_back({8'h41, 3'b000});
        send_frame(8'h41, 7, 1'b1, 1'b0, 1'b1, K11, -1, 1'b0);
        idle(20); pulse_read();

        // 8O1: 0xA3 has four ones, odd parity bit 1
        EIGHT = 1'b1; OHEL = 1'b1;
        exp_q.push_back({8'hA3, 3'b000});
        send_frame(8'hA3, 8, 1'b1, 1'b1, 1'b1, K11, -1, 1'b0);
        idle(20); pulse_read();

        // Framing error, line stays low afterwards: no further frame until it returns high
        PEN = 1'b0; OHEL = 1'b0;
        exp_q.push_back({8'hA3, 3'b010});
        send_frame(8'hA3, 8, 1'b0, 1'b0, 1'b0, K11, -1, 1'b0);
        repeat (3 * K11) @(negedge clk);
        chk("ferr_held", FERR, 1'b1);
        idle(2 * K11); pulse_read();

        // Break: line low for well over a frame
        exp_q.push_back({8'h00, 3'b010});
        RX = 1'b0;
        repeat (12 * K11) @(negedge clk);
        idle(2 * K11); pulse_read();

        // Overrun: two frames without READ
        exp_q.push_back({8'h11, 3'b000});
        send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1, K11, -1, 1'b0);
        idle(20);
        exp_q.push_back({8'h22, 3'b001});
        send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1, K11, -1, 1'b0);
        idle(20); pulse_read();

        // READ coincident with completion: completion wins, OVF stays 0
        exp_q.push_back({8'h33, 3'b000});
        send_frame(8'h33, 8, 1'b0, 1'b0, 1'b1, K11, -1, 1'b0);
        idle(20);
        exp_q.push_back({8'h44, 3'b000});
        send_frame(8'h44, 8, 1'b0, 1'b0, 1'b1, K11, -1, 1'b1);
        chk("read_at_done_rdy_ovf", {RXRDY, OVF}, 2'b10);
        idle(20); pulse_read();

`ifdef RX_MAJORITY_EN
        gb = 3;
`else
        gb = -1;
`endif
        exp_q.push_back({8'h5A, 3'b000});
        send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b1, K11, gb, 1'b0);
        idle(20); pulse_read();

        // 7N1 with all-ones data: bit 7 must read back 0
        EIGHT = 1'b0;
        exp_q.push_back({8'h7F, 3'b000});
        send_frame(8'hFF, 7, 1'b0, 1'b0, 1'b1, K11, -1, 1'b0);
        idle(20);

        // Reset after the fourth data bit aborts the frame
        EIGHT = 1'b1;
        @(negedge clk);
        RX = 1'b0;
        repeat (5 * K11) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("reset_midframe", {rx_data, RXRDY, PERR, FERR, OVF}, {8'h00, 4'b0000});
        RX = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(2 * K11);
        exp_q.push_back({8'h7E, 3'b000});
        send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1, K11, -1, 1'b0);
        idle(50);

        for (int i = 0; i < 5000 && exp_q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_engine.md
Name: uart_rx_engine

Overview:
- UART receive engine; the serial-in counterpart of the transmit engine in the full UART.
- Detects the start bit, samples each bit at mid-bit-time, deserialises 7/8 data bits with optional parity, and flags parity, framing and overrun errors.
- Sits between the synchronised RX pin and the processor-side register interface (RXRDY/READ handshake).

Parameters:
- SYNC_STAGES, 2, number of flops in the RX input synchroniser (minimum 2).
- BT_W, 19, bit-time counter width; must hold the largest baud-table entry.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  reset; asynchronous, active-high.
- RX  in  1  serial input, idle high, asynchronous to clk.
- BAUD  in  4  baud select; indexes the shared baud table.
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits.
- PEN  in  1  parity enable.
- OHEL  in  1  parity sense: 1 = odd, 0 = even.
- READ  in  1  one-cycle pulse; consumes the received byte.
- rx_data  out  8  received data; bit 7 = 0 in 7-bit mode.
- RXRDY  out  1  a new byte is valid.
- PERR  out  1  parity error on the held byte.
- FERR  out  1  framing error: stop bit sampled 0.
- OVF  out  1  overrun: a new frame completed while RXRDY was still 1.

Behaviour:
- Reset: all outputs 0, FSM to IDLE, counters 0, shift register all 1s, synchroniser all 1s.
- RX passes through SYNC_STAGES flops; rxs is the synchronised value.
- Configuration latch: BAUD, EIGHT, PEN and OHEL are latched on IDLE->START. Changes mid-frame have no effect on the frame in progress.
- Bit time: k = BAUD_TBL[BAUD], half = k>>1.
- Frame length: n = 1 + (EIGHT?8:7) + PEN + 1, giving 9..11 samples.
- IDLE:
  - rxs == 0 -> START; bit-time counter loads half; bit counter = 0.
- START:
  - When the counter expires, sample rxs.
  - rxs == 0 -> DATA; counter loads k; bit counter = 1.
  - rxs == 1 -> IDLE (false start; no flags change).
- DATA:
  - On each counter expiry: shift sample into SR[9] (10-bit SR, right shift); bit counter +1; counter reloads k.
  - When bit counter reaches n, the frame completes:
    - w = SR >> (11-n).
    - rx_data = EIGHT ? w[7:0] : {0,w[6:0]}.
    - Parity bit = w[dbits]; stop bit = w[n-2].
    - PERR = PEN & (parity bit != (OHEL ? ~^data : ^data)).
    - FERR = ~stop bit.
    - OVF = old RXRDY.
    - RXRDY = 1.
    - FSM -> IDLE in the same cycle.
  - Outputs update on the clock edge after the stop-bit sample: 1 cycle latency.
- Counter expiry means the count reaches 1. A loaded value L expires L cycles after the load.
- READ clears RXRDY, PERR, FERR and OVF on the next edge.
  - If READ coincides with frame completion, completion wins: the new flags are set and OVF = 0.
- rx_data holds until the next completed frame; READ does not clear it.
- Back-to-back frames: a start edge seen in the same cycle as completion is taken on the following IDLE cycle. Loss is at most 1 cycle.
- Line held low (break): FERR = 1 and data 0x00. The FSM then stays in IDLE until rxs == 1 is seen, then re-arms.
- Reset mid-frame: immediate abort; the partial frame is discarded.

Optional Feature:
- RX_MAJORITY_EN defined: each START/DATA sample is the 2-of-3 majority of rxs at counter values 3, 2 and 1, which suppresses single-cycle glitches.
- RX_MAJORITY_EN undefined: single sample of rxs at expiry.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding: IDLE, START, DATA.
  - BAUD_TBL[16] at 100 MHz: 333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736, 868, 434, 217, 109; indices 12-15 = 109.
  - Frame-length constants.
- One sub-module: uart_bit_timer, a loadable down-counter with an expire strobe. It is shared with the transmit engine.

Test Plan:
- BAUD=8 (k=868), 8N1, frame 0x55 -> RXRDY rises about 868*9.5 cycles after the start edge; rx_data=0x55; PERR, FERR, OVF = 0. Then READ -> all flags 0.
- BAUD=8, EIGHT=0, PEN=1, OHEL=0, data 0x41, parity bit driven 1 -> rx_data=0x41, PERR=1. Repeat with parity bit 0 -> PERR=0.
- 8N1 frame 0xA3 with stop bit driven 0 -> rx_data=0xA3, FERR=1. No new frame until the line returns high.
- Two frames 0x11 then 0x22 with no READ -> rx_data=0x22, OVF=1. READ coincident with second completion -> OVF=0, RXRDY=1.
- RX low pulse of 300 cycles at BAUD=8 -> returns to IDLE; RXRDY stays 0. With RX_MAJORITY_EN, a 1-cycle high glitch at a sample point does not change rx_data.
- rst asserted mid-frame after bit 4 -> outputs 0 immediately; a following valid frame 0x7E is received correctly.
